obuf_read_arbiter: RTL and testbench
====================================

Name: obuf_read_arbiter

Overview:
Shares the single read port of the banked output buffer between two requesters: the systolic-array accumulate path (SA, partial-sum read-back) and the store engine (ST, drain to DDR). Grants at most one row read per cycle, broadcasting one address to all banks. Tracks every in-flight read through the buffer's read latency so that the returning-data valid reaches only the requester that issued it. Sits between the systolic controller/store engine and the output buffer read ports. Read data wires connect directly to both requesters and do not pass through this block.

Parameters:
NUM_BANKS, 64, number of output-buffer banks driven in parallel
READ_ADDR_WIDTH, 8, per-bank read address width
READ_LATENCY, 1, output-buffer read latency in cycles; must be at least 1
STARVE_LIMIT, 8, consecutive cycles ST may wait before it is promoted over SA; must be at least 1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
sa_rd_req  in  1  SA read request; held until accepted
sa_rd_addr  in  READ_ADDR_WIDTH  SA row address
sa_rd_ready  out  1  SA request accepted this cycle (combinational grant)
sa_rd_data_valid  out  1  obuf data on the read-data bus belongs to SA this cycle
st_rd_req  in  1  ST read request; held until accepted
st_rd_addr  in  READ_ADDR_WIDTH  ST row address
st_rd_ready  out  1  ST request accepted this cycle
st_rd_data_valid  out  1  obuf data belongs to ST this cycle
obuf_rd_req  out  NUM_BANKS  per-bank read enable to the output buffer
obuf_rd_addr  out  NUM_BANKS*READ_ADDR_WIDTH  per-bank read address, same value replicated in every slice
starve_flag  out  1  ST is currently promoted

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high.
- Outputs in reset: all outputs are 0, the starve counter is 0, and the response pipe is cleared.
- Accept rule: a request is accepted in cycle t when req=1 and ready=1. The ready outputs are combinational from the req inputs and the promotion state.
- At most one of sa_rd_ready and st_rd_ready is high in any cycle. A ready is never high while its own req is low.
- Normal priority: SA has priority. If both requesters are active, sa_rd_ready=1 and st_rd_ready=0.
- Promotion: when starve_flag=1 and st_rd_req=1, ST wins and SA is stalled that cycle.
- Starve counter, per cycle:
  - ST requesting and not granted: counter increments.
  - ST granted, or st_rd_req=0: counter clears to 0.
  - The counter saturates at STARVE_LIMIT.
  - starve_flag = (counter == STARVE_LIMIT), registered.
- Worst-case wait: ST is therefore granted at most STARVE_LIMIT+1 cycles after it first requests, even under continuous SA traffic.
- Issue stage (registered): on accept in cycle t, in cycle t+1 drive obuf_rd_req = all ones and every obuf_rd_addr slice = the accepted address. With no accept in cycle t, obuf_rd_req is all zeros in t+1; obuf_rd_addr holds its last value.
- Response pipe: a READ_LATENCY-deep shift register of {valid, owner_id}, loaded in t+1. In cycle t+1+READ_LATENCY, exactly one of sa_rd_data_valid or st_rd_data_valid is 1, matching the owner.
- Pipelining: back-to-back accepts are supported. One grant per cycle gives one valid per cycle, in grant order. There is no response backpressure; requesters must take the data.
- Reset mid-operation: in-flight entries are dropped. No data-valid pulses appear after reset for reads accepted before it.
- Address changes while req is held and not ready are allowed. The address sampled on the accept cycle is the one issued.

Test Plan:
- Single SA read, READ_LATENCY=1: sa_rd_req=1 with addr 0x12 in cycle 0 → sa_rd_ready=1 in cycle 0; obuf_rd_req=all ones and all 64 address slices =0x12 in cycle 1; sa_rd_data_valid=1 only in cycle 2; st_rd_data_valid stays 0.
- Simultaneous requests: SA at addr 0x03 and ST at addr 0x40 both request in cycle 0 → SA granted in cycle 0, ST granted in cycle 1. Issued addresses are 0x03 in cycle 1 and 0x40 in cycle 2. Valids are SA in cycle 2 and ST in cycle 3.
- Starvation, STARVE_LIMIT=8: SA requests every cycle from cycle 0 and ST from cycle 0 → starve_flag=1 in cycle 8, st_rd_ready=1 in cycle 8, sa_rd_ready=0 in cycle 8. The counter returns to 0 and SA resumes in cycle 9.
- Latency sweep, READ_LATENCY=3: alternate SA and ST grants for 10 cycles → valids are the grant sequence delayed by exactly 4 cycles, never both high in the same cycle, in order.
- Reset mid-flight, READ_LATENCY=3: grant SA in cycle 0, assert reset in cycle 2 → no sa_rd_data_valid pulse in cycle 4. After reset deasserts, all outputs read 0 until the next request.
- Idle behaviour: no requests for 5 cycles → obuf_rd_req=0 throughout, starve_flag=0, both valids 0.

Source files
------------

// File: rtl/obuf_read_arbiter_if.sv
// Handshake bundle between the SA/ST requesters, the read arbiter and the
// output-buffer read port.
interface obuf_read_arbiter_if #(
    parameter int NUM_BANKS       = 64,
    parameter int READ_ADDR_WIDTH = 8
);
    logic                                 sa_rd_req;
    logic [READ_ADDR_WIDTH-1:0]           sa_rd_addr;
    logic                                 sa_rd_ready;
    logic                                 sa_rd_data_valid;
    logic                                 st_rd_req;
    logic [READ_ADDR_WIDTH-1:0]           st_rd_addr;
    logic                                 st_rd_ready;
    logic                                 st_rd_data_valid;
    logic [NUM_BANKS-1:0]                 obuf_rd_req;
    logic [NUM_BANKS*READ_ADDR_WIDTH-1:0] obuf_rd_addr;
    logic                                 starve_flag;

    modport slave (
        input  sa_rd_req, sa_rd_addr, st_rd_req, st_rd_addr,
        output sa_rd_ready, sa_rd_data_valid, st_rd_ready, st_rd_data_valid,
        output obuf_rd_req, obuf_rd_addr, starve_flag
    );

    modport master (
        output sa_rd_req, sa_rd_addr, st_rd_req, st_rd_addr,
        input  sa_rd_ready, sa_rd_data_valid, st_rd_ready, st_rd_data_valid,
        input  obuf_rd_req, obuf_rd_addr, starve_flag
    );
endinterface

// File: rtl/obuf_read_arbiter.sv
// Arbitrates the output-buffer read port between the SA partial-sum path and
// the store engine, and routes each returning data-valid back to its issuer.
module obuf_read_arbiter #(
    parameter int NUM_BANKS       = 64,
    parameter int READ_ADDR_WIDTH = 8,
    parameter int READ_LATENCY    = 1,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    obuf_read_arbiter_if.slave   bus
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic                       sa_win_s;
    logic                       st_win_s;
    logic [READ_ADDR_WIDTH-1:0] accept_addr_s;
    logic [CNT_W-1:0]           cnt_next_s;
    logic [CNT_W-1:0]           cnt_r;
    logic                       starve_r;
    logic                       issue_sa_r;
    logic                       issue_st_r;
    logic [READ_ADDR_WIDTH-1:0] addr_r;
    logic [READ_LATENCY-1:0]    pipe_sa_r;
    logic [READ_LATENCY-1:0]    pipe_st_r;

    // Grant selection: SA first unless ST has been promoted; nothing granted in reset
    always_comb begin
        sa_win_s      = 1'b0;
        st_win_s      = 1'b0;
        accept_addr_s = bus.sa_rd_addr;
        if (reset) begin
            sa_win_s = 1'b0;
            st_win_s = 1'b0;
        end else if (bus.st_rd_req && (starve_r || !bus.sa_rd_req)) begin
            st_win_s      = 1'b1;
            accept_addr_s = bus.st_rd_addr;
        end else if (bus.sa_rd_req) begin
            sa_win_s = 1'b1;
        end else begin
            sa_win_s = 1'b0;
            st_win_s = 1'b0;
        end
    end

    // Starve counter next value: counts ST wait cycles, saturating at the limit
    always_comb begin
        cnt_next_s = cnt_r;
        if (!bus.st_rd_req || st_win_s) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else if (cnt_r == LIMIT) begin
            cnt_next_s = cnt_r;
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    // Promotion state, issue stage and response pipe
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r      <= {CNT_W{1'b0}};
            starve_r   <= 1'b0;
            issue_sa_r <= 1'b0;
            issue_st_r <= 1'b0;
            addr_r     <= {READ_ADDR_WIDTH{1'b0}};
            pipe_sa_r  <= {READ_LATENCY{1'b0}};
            pipe_st_r  <= {READ_LATENCY{1'b0}};
        end else begin
            cnt_r      <= cnt_next_s;
            starve_r   <= (cnt_next_s == LIMIT);
            issue_sa_r <= sa_win_s;
            issue_st_r <= st_win_s;
            if (sa_win_s || st_win_s) begin
                addr_r <= accept_addr_s;
            end else begin
                addr_r <= addr_r;
            end
            // Owner is carried one-hot so each data-valid is a direct register bit
            pipe_sa_r[0] <= issue_sa_r;
            pipe_st_r[0] <= issue_st_r;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_sa_r[i] <= pipe_sa_r[i-1];
                pipe_st_r[i] <= pipe_st_r[i-1];
            end
        end
    end

    assign bus.sa_rd_ready      = sa_win_s;
    assign bus.st_rd_ready      = st_win_s;
    assign bus.starve_flag      = starve_r;
    assign bus.obuf_rd_req      = {NUM_BANKS{issue_sa_r | issue_st_r}};
    assign bus.obuf_rd_addr     = {NUM_BANKS{addr_r}};
    assign bus.sa_rd_data_valid = pipe_sa_r[READ_LATENCY-1];
    assign bus.st_rd_data_valid = pipe_st_r[READ_LATENCY-1];
endmodule

// File: tb/tb_obuf_read_arbiter.sv
// Directed bench for obuf_read_arbiter: one instance with read latency 1 and
// one with read latency 3, both with a starve limit of 8.
module tb_obuf_read_arbiter;
    logic clk;
    logic reset1;
    logic reset3;
    int   tests;
    int   fails;

    localparam logic [63:0] ALL1 = {64{1'b1}};

    obuf_read_arbiter_if #(.NUM_BANKS(64), .READ_ADDR_WIDTH(8)) b1 ();
    obuf_read_arbiter_if #(.NUM_BANKS(64), .READ_ADDR_WIDTH(8)) b3 ();

    obuf_read_arbiter #(.NUM_BANKS(64), .READ_ADDR_WIDTH(8), .READ_LATENCY(1), .STARVE_LIMIT(8))
        u1 (.clk(clk), .reset(reset1), .bus(b1));
    obuf_read_arbiter #(.NUM_BANKS(64), .READ_ADDR_WIDTH(8), .READ_LATENCY(3), .STARVE_LIMIT(8))
        u3 (.clk(clk), .reset(reset3), .bus(b3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle(input int n);
        b1.sa_rd_req = 1'b0; b1.st_rd_req = 1'b0;
        b3.sa_rd_req = 1'b0; b3.st_rd_req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        reset1 = 1'b1; reset3 = 1'b1;
        b1.sa_rd_req = 1'b1; b1.st_rd_req = 1'b1; b1.sa_rd_addr = 8'h00; b1.st_rd_addr = 8'h00;
        b3.sa_rd_req = 1'b1; b3.st_rd_req = 1'b1; b3.sa_rd_addr = 8'h00; b3.st_rd_addr = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        obs = {b1.sa_rd_ready, b1.st_rd_ready, b1.sa_rd_data_valid, b1.st_rd_data_valid,
               b1.starve_flag, |b1.obuf_rd_req};
        tests++;
        if (obs !== 6'b0) begin fails++; $display("FAIL reset_l1 outputs got %b want 000000", obs); end
        obs = {b3.sa_rd_ready, b3.st_rd_ready, b3.sa_rd_data_valid, b3.st_rd_data_valid,
               b3.starve_flag, |b3.obuf_rd_req};
        tests++;
        if (obs !== 6'b0) begin fails++; $display("FAIL reset_l3 outputs got %b want 000000", obs); end
        tests++;
        if (b1.obuf_rd_addr !== 512'b0) begin fails++; $display("FAIL reset_l1 obuf_rd_addr got %h want 0", b1.obuf_rd_addr); end
        @(negedge clk);
        reset1 = 1'b0; reset3 = 1'b0;
        idle(3);
    endtask

    task automatic test_single_sa();
        @(negedge clk);
        b1.sa_rd_req = 1'b1; b1.sa_rd_addr = 8'h12;
        #1;
        tests++;
        if ({b1.sa_rd_ready, b1.st_rd_ready} !== 2'b10) begin fails++; $display("FAIL single_sa c0 ready got %b want 10", {b1.sa_rd_ready, b1.st_rd_ready}); end
        @(negedge clk);
        b1.sa_rd_req = 1'b0;
        #1;
        tests++;
        if (b1.obuf_rd_req !== ALL1) begin fails++; $display("FAIL single_sa c1 obuf_rd_req got %h want all ones", b1.obuf_rd_req); end
        tests++;
        if (b1.obuf_rd_addr !== {64{8'h12}}) begin fails++; $display("FAIL single_sa c1 obuf_rd_addr got %h want 12 x64", b1.obuf_rd_addr); end
        tests++;
        if ({b1.sa_rd_data_valid, b1.st_rd_data_valid} !== 2'b00) begin fails++; $display("FAIL single_sa c1 valids got %b want 00", {b1.sa_rd_data_valid, b1.st_rd_data_valid}); end
        @(negedge clk);
        #1;
        tests++;
        if ({b1.sa_rd_data_valid, b1.st_rd_data_valid} !== 2'b10) begin fails++; $display("FAIL single_sa c2 valids got %b want 10", {b1.sa_rd_data_valid, b1.st_rd_data_valid}); end
        tests++;
        if (b1.obuf_rd_req !== 64'b0) begin fails++; $display("FAIL single_sa c2 obuf_rd_req got %h want 0", b1.obuf_rd_req); end
        @(negedge clk);
        #1;
        tests++;
        if ({b1.sa_rd_data_valid, b1.st_rd_data_valid} !== 2'b00) begin fails++; $display("FAIL single_sa c3 valids got %b want 00", {b1.sa_rd_data_valid, b1.st_rd_data_valid}); end
        idle(2);
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        b1.sa_rd_req = 1'b1; b1.sa_rd_addr = 8'h03;
        b1.st_rd_req = 1'b1; b1.st_rd_addr = 8'h40;
        #1;
        tests++;
        if ({b1.sa_rd_ready, b1.st_rd_ready} !== 2'b10) begin fails++; $display("FAIL simul c0 ready got %b want 10", {b1.sa_rd_ready, b1.st_rd_ready}); end
        @(negedge clk);
        b1.sa_rd_req = 1'b0;
        #1;
        tests++;
        if ({b1.sa_rd_ready, b1.st_rd_ready} !== 2'b01) begin fails++; $display("FAIL simul c1 ready got %b want 01", {b1.sa_rd_ready, b1.st_rd_ready}); end
        tests++;
        if (b1.obuf_rd_addr !== {64{8'h03}} || b1.obuf_rd_req !== ALL1) begin fails++; $display("FAIL simul c1 issue got req %h addr %h want all ones / 03", b1.obuf_rd_req, b1.obuf_rd_addr); end
        @(negedge clk);
        b1.st_rd_req = 1'b0;
        #1;
        tests++;
        if (b1.obuf_rd_addr !== {64{8'h40}} || b1.obuf_rd_req !== ALL1) begin fails++; $display("FAIL simul c2 issue got req %h addr %h want all ones / 40", b1.obuf_rd_req, b1.obuf_rd_addr); end
        tests++;
        if ({b1.sa_rd_data_valid, b1.st_rd_data_valid} !== 2'b10) begin fails++; $display("FAIL simul c2 valids got %b want 10", {b1.sa_rd_data_valid, b1.st_rd_data_valid}); end
        @(negedge clk);
        #1;
        tests++;
        if ({b1.sa_rd_data_valid, b1.st_rd_data_valid} !== 2'b01) begin fails++; $display("FAIL simul c3 valids got %b want 01", {b1.sa_rd_data_valid, b1.st_rd_data_valid}); end
        @(negedge clk);
        #1;
        tests++;
        if ({b1.sa_rd_data_valid, b1.st_rd_data_valid} !== 2'b00) begin fails++; $display("FAIL simul c4 valids got %b want 00", {b1.sa_rd_data_valid, b1.st_rd_data_valid}); end
        idle(2);
    endtask

    task automatic test_addr_change();
        @(negedge clk);
        b1.sa_rd_req = 1'b1; b1.sa_rd_addr = 8'h01;
        b1.st_rd_req = 1'b1; b1.st_rd_addr = 8'h11;
        @(negedge clk);
        b1.sa_rd_req = 1'b0; b1.st_rd_addr = 8'h22;
        #1;
        tests++;
        if (b1.st_rd_ready !== 1'b1) begin fails++; $display("FAIL addr_change c1 st_rd_ready got %b want 1", b1.st_rd_ready); end
        @(negedge clk);
        b1.st_rd_req = 1'b0;
        #1;
        tests++;
        if (b1.obuf_rd_addr !== {64{8'h22}}) begin fails++; $display("FAIL addr_change c2 obuf_rd_addr got %h want 22 x64", b1.obuf_rd_addr); end
        idle(3);
    endtask

    task automatic test_starvation();
        logic [2:0] exp;
        logic [2:0] obs;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            b1.sa_rd_req = 1'b1; b1.sa_rd_addr = 8'(k);
            b1.st_rd_req = (k <= 8); b1.st_rd_addr = 8'hA5;
            #1;
            exp = (k == 8) ? 3'b011 : 3'b100;
            obs = {b1.sa_rd_ready, b1.st_rd_ready, b1.starve_flag};
            tests++;
            if (obs !== exp) begin fails++; $display("FAIL starve c%0d sa_ready/st_ready/flag got %b want %b", k, obs, exp); end
        end
        idle(4);
    endtask

    task automatic test_latency_sweep();
        logic [3:0] exp;
        logic [3:0] obs;
        for (int m = 0; m < 16; m++) begin
            @(negedge clk);
            b3.sa_rd_req = (m < 10) && (m % 2 == 0);
            b3.st_rd_req = (m < 10) && (m % 2 == 1);
            b3.sa_rd_addr = 8'(m); b3.st_rd_addr = 8'(m + 8'h80);
            #1;
            exp[3] = (m < 10) && (m % 2 == 0);
            exp[2] = (m < 10) && (m % 2 == 1);
            exp[1] = (m >= 4) && (m < 14) && ((m - 4) % 2 == 0);
            exp[0] = (m >= 4) && (m < 14) && ((m - 4) % 2 == 1);
            obs = {b3.sa_rd_ready, b3.st_rd_ready, b3.sa_rd_data_valid, b3.st_rd_data_valid};
            tests++;
            if (obs !== exp) begin fails++; $display("FAIL lat_sweep c%0d ready/valids got %b want %b", m, obs, exp); end
        end
        idle(2);
    endtask

    task automatic test_reset_midflight();
        logic [5:0] obs;
        @(negedge clk);
        b3.sa_rd_req = 1'b1; b3.sa_rd_addr = 8'h05;
        #1;
        tests++;
        if (b3.sa_rd_ready !== 1'b1) begin fails++; $display("FAIL rst_mid c0 sa_rd_ready got %b want 1", b3.sa_rd_ready); end
        @(negedge clk);
        b3.sa_rd_req = 1'b0;
        @(negedge clk);
        reset3 = 1'b1;
        @(negedge clk);
        reset3 = 1'b0;
        for (int k = 3; k < 7; k++) begin
            #1;
            obs = {b3.sa_rd_ready, b3.st_rd_ready, b3.sa_rd_data_valid, b3.st_rd_data_valid,
                   b3.starve_flag, |b3.obuf_rd_req};
            tests++;
            if (obs !== 6'b0) begin fails++; $display("FAIL rst_mid c%0d outputs got %b want 000000", k, obs); end
            @(negedge clk);
        end
        idle(1);
    endtask

    task automatic test_idle();
        logic [3:0] obs;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            obs = {|b1.obuf_rd_req, b1.starve_flag, b1.sa_rd_data_valid, b1.st_rd_data_valid};
            tests++;
            if (obs !== 4'b0) begin fails++; $display("FAIL idle c%0d req/flag/valids got %b want 0000", k, obs); end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single_sa();
        test_simultaneous();
        test_addr_change();
        test_starvation();
        test_latency_sweep();
        test_reset_midflight();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
